// File: rtl/cascade_and_checker_pkg.sv
// -----------------------------------------------------------------------------
// cascade_pkg
// Shared definitions for the cascade-AND response checker: the campaign FSM
// state encoding, default vector/counter widths and the saturation ceiling of
// the default-width error counter.
// No ports (package).
// -----------------------------------------------------------------------------
package cascade_pkg;

  // Campaign sequencing: wait, prime the delay line, compare, report.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = 16;

  // Largest value a default-width counter can hold; the error count sticks here.
  localparam logic [CNT_W_DEFAULT-1:0] CNT_SAT_MAX = '1;

endpackage

// File: rtl/cascade_and_checker_if.sv
// -----------------------------------------------------------------------------
// cascade_and_checker_if
// Bundles the checker's campaign handshake, the stimulus/response pair it
// watches and its result outputs.
//   master : harness side - drives start, stim, dut_y; reads results
//   slave  : checker side - reads start, stim, dut_y; drives results
// Signals:
//   start            single-cycle pulse that begins a campaign
//   stim             stimulus vector currently applied to the DUT
//   dut_y            DUT response
//   busy / done      campaign running / campaign finished
//   pass             valid with done; 1 when no mismatch was seen
//   err_count        mismatches in the current/last campaign (saturating)
//   vec_count        vectors compared so far
//   first_fail_vec   stimulus of the first mismatch
//   first_fail_valid first_fail_vec holds a captured value
// -----------------------------------------------------------------------------
interface cascade_and_checker_if #(
  parameter int WIDTH = cascade_pkg::WIDTH_DEFAULT,
  parameter int CNT_W = cascade_pkg::CNT_W_DEFAULT
) ();

  logic             start;
  logic [WIDTH-1:0] stim;
  logic             dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] vec_count;
  logic [WIDTH-1:0] first_fail_vec;
  logic             first_fail_valid;

  modport master (
    output start, stim, dut_y,
    input  busy, done, pass, err_count, vec_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, stim, dut_y,
    output busy, done, pass, err_count, vec_count, first_fail_vec, first_fail_valid
  );

endinterface

// File: rtl/cascade_and_checker_stim_delay_line.sv
// -----------------------------------------------------------------------------
// stim_delay_line
// Delays the stimulus vector by LATENCY clock cycles so it lines up with the
// DUT response it produced. LATENCY=0 is a plain wire.
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset, clears every stage
//   shift_en_i  advance the line by one stage this cycle
//   stim_i      stimulus entering the line
//   stim_o      stimulus from LATENCY enabled cycles ago
// -----------------------------------------------------------------------------
module stim_delay_line #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] stim_i,
  output logic [WIDTH-1:0] stim_o
);

  if (LATENCY == 0) begin : g_pass

    // Zero latency: the DUT answers combinationally, so compare against the
    // live stimulus; clock, reset and enable have nothing to do here.
    logic unusedCtrl;
    assign unusedCtrl = &{1'b0, clk, rst_n, shift_en_i};
    assign stim_o     = stim_i;

  end else begin : g_shift

    logic [WIDTH-1:0] stage_q [LATENCY];

    // Shift register: stage 0 takes the live stimulus, the oldest entry sits
    // in the last stage. It only moves while the checker is filling or running.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LATENCY; i++) begin
          stage_q[i] <= '0;
        end
      end else if (shift_en_i) begin
        stage_q[0] <= stim_i;
        for (int i = 1; i < LATENCY; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign stim_o = stage_q[LATENCY-1];

  end

endmodule

// File: rtl/cascade_and_checker.sv
// -----------------------------------------------------------------------------
// cascade_and_checker
// Runs a fixed-length check campaign against a cascade-AND DUT: each compared
// cycle the DUT output must equal the reduction-AND of the stimulus applied
// LATENCY cycles earlier. Reports pass/fail, a saturating error count, the
// number of compared vectors and the first failing stimulus.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    cascade_and_checker_if.slave - start/stim/dut_y in, results out
// Parameters: WIDTH (stimulus width), LATENCY (0..15 DUT delay in cycles),
//   NUM_VECTORS (1..65535 compares per campaign), CNT_W (counter width).
// -----------------------------------------------------------------------------
module cascade_and_checker
  import cascade_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int LATENCY     = 0,
  parameter int NUM_VECTORS = 256,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  cascade_and_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] SatMax   = '1;
  localparam logic [CNT_W-1:0] LastVec  = CNT_W'(NUM_VECTORS - 1);
  localparam logic [3:0]       FillLast = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t           state_q;
  logic [3:0]       fillCnt_q;
  logic [CNT_W-1:0] vecCount_q;
  logic [CNT_W-1:0] errCount_q;
  logic [WIDTH-1:0] firstFailVec_q;
  logic             firstFailValid_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [WIDTH-1:0] stimDelayed;
  logic             shiftEn;
  logic             expected;
  logic             mismatch;
  logic [CNT_W-1:0] errCount_d;
  logic             lastCompare;

  // The delay line keeps moving through FILL and RUN; whatever it held from an
  // earlier campaign is flushed out by the FILL phase before any compare.
  assign shiftEn = (state_q == FILL) || (state_q == RUN);

  stim_delay_line #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (shiftEn),
    .stim_i     (bus.stim),
    .stim_o     (stimDelayed)
  );

  // Comparator and next error count. Case-inequality makes an X/Z response
  // count as a mismatch in simulation; the counter sticks at its ceiling.
  always_comb begin
    expected    = &stimDelayed;
    mismatch    = (bus.dut_y !== expected);
    errCount_d  = errCount_q;
    if (mismatch && (errCount_q != SatMax)) begin
      errCount_d = errCount_q + CNT_W'(1);
    end
    lastCompare = (vecCount_q == LastVec);
  end

  // Campaign FSM with all result registers. A start in IDLE or DONE clears the
  // results and launches a campaign; a start in FILL/RUN is ignored. The final
  // compare also loads busy/done/pass so they flip on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      fillCnt_q        <= '0;
      vecCount_q       <= '0;
      errCount_q       <= '0;
      firstFailVec_q   <= '0;
      firstFailValid_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q          <= (LATENCY > 0) ? FILL : RUN;
            fillCnt_q        <= '0;
            vecCount_q       <= '0;
            errCount_q       <= '0;
            firstFailVec_q   <= '0;
            firstFailValid_q <= 1'b0;
            busy_q           <= 1'b1;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
          end
        end
        FILL: begin
          if (fillCnt_q == FillLast) begin
            state_q <= RUN;
          end else begin
            fillCnt_q <= fillCnt_q + 4'd1;
          end
        end
        RUN: begin
          vecCount_q <= vecCount_q + CNT_W'(1);
          errCount_q <= errCount_d;
          if (mismatch && !firstFailValid_q) begin
            firstFailVec_q   <= stimDelayed;
            firstFailValid_q <= 1'b1;
          end
          if (lastCompare) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (errCount_d == '0);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = errCount_q;
  assign bus.vec_count        = vecCount_q;
  assign bus.first_fail_vec   = firstFailVec_q;
  assign bus.first_fail_valid = firstFailValid_q;

endmodule

// File: tb/tb_cascade_and_checker.sv
// -----------------------------------------------------------------------------
// tb_cascade_and_checker
// Two checkers share one stimulus stream: checker A (LATENCY=0) watches a
// selectable DUT model (ideal AND, stuck-at-0, stuck-at-1, two-stage
// registered AND); checker B (LATENCY=2) always watches the two-stage DUT.
// A scoreboard predicts checker A's running counters for every compared
// vector; the scenario tasks check campaign results and handshake behaviour.
// -----------------------------------------------------------------------------
module tb_cascade_and_checker;
  import cascade_pkg::*;

  localparam int W  = 8;
  localparam int CW = 16;
  localparam int NV = 256;

  logic clk = 1'b0;
  logic rst_n;

  // 100 MHz clock for the whole bench.
  always #5 clk = ~clk;

  cascade_and_checker_if #(.WIDTH(W), .CNT_W(CW)) busA ();
  cascade_and_checker_if #(.WIDTH(W), .CNT_W(CW)) busB ();

  cascade_and_checker #(.WIDTH(W), .LATENCY(0), .NUM_VECTORS(NV), .CNT_W(CW)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  cascade_and_checker #(.WIDTH(W), .LATENCY(2), .NUM_VECTORS(NV), .CNT_W(CW)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  // DUT under check for A: 0 ideal AND, 1 stuck-at-0, 2 stuck-at-1, 3 two-stage.
  int   kind = 0;
  logic pipe1, pipe2;

  // Two-stage registered cascade-AND DUT: output is &stim from two cycles ago.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe1 <= 1'b0;
      pipe2 <= 1'b0;
    end else begin
      pipe1 <= &busA.stim;
      pipe2 <= pipe1;
    end
  end

  assign busA.dut_y = (kind == 0) ? &busA.stim :
                      (kind == 1) ? 1'b0 :
                      (kind == 2) ? 1'b1 : pipe2;
  assign busB.stim  = busA.stim;
  assign busB.dut_y = pipe2;

  typedef struct packed {
    logic [CW-1:0] vec;
    logic [CW-1:0] err;
    logic          ffv;
    logic [W-1:0]  ffvec;
  } sb_t;

  sb_t sbQ [$];
  sb_t sbExp, sbObs;
  int  vecApplied  = 0;
  int  miscompares = 0;

  logic [W-1:0]  hist0 = '0, hist1 = '0, hist2 = '0;
  logic [CW-1:0] mVec, mErr;
  logic          mFfv;
  logic [W-1:0]  mFfvec;

  task automatic resetModel();
    mVec   = '0;
    mErr   = '0;
    mFfv   = 1'b0;
    mFfvec = '0;
  endtask

  // Drive one cycle of inputs at the falling edge. When score is set the cycle
  // is a checker-A compare cycle: predict the DUT response and the checker's
  // counters after this compare and queue them for the scoreboard.
  task automatic applyStimulus(input logic [W-1:0] s, input logic stA,
                               input logic stB, input bit score);
    logic y;
    logic want;
    @(negedge clk);
    busA.stim  = s;
    busA.start = stA;
    busB.start = stB;
    hist2 = hist1;
    hist1 = hist0;
    hist0 = s;
    if (score) begin
      case (kind)
        0:       y = &s;
        1:       y = 1'b0;
        2:       y = 1'b1;
        default: y = &hist2;
      endcase
      want = &s;
      mVec = mVec + 1'b1;
      if (y !== want) begin
        if (mErr != CNT_SAT_MAX) mErr = mErr + 1'b1;
        if (!mFfv) begin
          mFfv   = 1'b1;
          mFfvec = s;
        end
      end
      sbQ.push_back('{mVec, mErr, mFfv, mFfvec});
    end
  endtask

  // Scoreboard: one edge after each queued compare, checker A's counters and
  // first-fail capture must match the prediction.
  always @(posedge clk) begin
    #1;
    if (sbQ.size() > 0) begin
      sbExp = sbQ.pop_front();
      sbObs = '{busA.vec_count, busA.err_count, busA.first_fail_valid, busA.first_fail_vec};
      vecApplied++;
      if (sbObs !== sbExp) begin
        miscompares++;
        $display("[TB] FAIL scoreboard: vec/err/ffv/ffvec got %0d/%0d/%0b/%02h, want %0d/%0d/%0b/%02h",
                 sbObs.vec, sbObs.err, sbObs.ffv, sbObs.ffvec,
                 sbExp.vec, sbExp.err, sbExp.ffv, sbExp.ffvec);
      end
    end
  end

  // Full checker-A campaign: a few quiet cycles, start with stim=0, then the
  // counter 0..NV-1 is compared; an optional start pulse lands at index pulseAt.
  task automatic runCampaignA(input int kindSel, input int pulseAt);
    kind = kindSel;
    repeat (3) applyStimulus('0, 1'b0, 1'b0, 1'b0);
    resetModel();
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NV; i++) applyStimulus(W'(i), (i == pulseAt), 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    busA.start = 1'b0;
    busB.start = 1'b0;
    busA.stim  = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    vecApplied++;
    if ({busA.busy, busA.done, busA.pass, busA.err_count, busA.vec_count,
         busA.first_fail_vec, busA.first_fail_valid} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_A: got busy=%0b done=%0b pass=%0b err=%0d vec=%0d, want all 0",
               busA.busy, busA.done, busA.pass, busA.err_count, busA.vec_count);
    end
    vecApplied++;
    if ({busB.busy, busB.done, busB.pass, busB.err_count, busB.vec_count,
         busB.first_fail_vec, busB.first_fail_valid} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_B: got busy=%0b done=%0b pass=%0b err=%0d vec=%0d, want all 0",
               busB.busy, busB.done, busB.pass, busB.err_count, busB.vec_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ideal();
    runCampaignA(0, -1);
    vecApplied++;
    if ({busA.busy, busA.done, busA.pass} !== 3'b011) begin
      miscompares++;
      $display("[TB] FAIL ideal_flags: busy/done/pass got %b%b%b, want 011", busA.busy, busA.done, busA.pass);
    end
    vecApplied++;
    if (busA.vec_count !== 16'd256 || busA.err_count !== 16'd0 || busA.first_fail_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ideal_counts: vec/err/ffv got %0d/%0d/%0b, want 256/0/0",
               busA.vec_count, busA.err_count, busA.first_fail_valid);
    end
  endtask

  task automatic test_stuck0();
    runCampaignA(1, -1);
    vecApplied++;
    if (busA.err_count !== 16'd1 || busA.first_fail_vec !== 8'hFF ||
        busA.first_fail_valid !== 1'b1 || busA.pass !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stuck0: err/ffvec/ffv/pass got %0d/%02h/%0b/%0b, want 1/ff/1/0",
               busA.err_count, busA.first_fail_vec, busA.first_fail_valid, busA.pass);
    end
  endtask

  task automatic test_stuck1();
    runCampaignA(2, -1);
    vecApplied++;
    if (busA.err_count !== 16'd255 || busA.first_fail_vec !== 8'h00 ||
        busA.first_fail_valid !== 1'b1 || busA.pass !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stuck1: err/ffvec/ffv/pass got %0d/%02h/%0b/%0b, want 255/00/1/0",
               busA.err_count, busA.first_fail_vec, busA.first_fail_valid, busA.pass);
    end
  endtask

  task automatic test_two_stage_no_latency();
    runCampaignA(3, -1);
    vecApplied++;
    if (busA.err_count !== 16'd1 || busA.first_fail_vec !== 8'hFF || busA.pass !== 1'b0 ||
        busA.done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL two_stage_lat0: err/ffvec/pass/done got %0d/%02h/%0b/%0b, want 1/ff/0/1",
               busA.err_count, busA.first_fail_vec, busA.pass, busA.done);
    end
  endtask

  task automatic test_latency2();
    int busyCycles = 0;
    bit gotDone    = 0;
    repeat (3) applyStimulus('0, 1'b0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 400 && !gotDone; i++) begin
      applyStimulus(W'(i), 1'b0, 1'b0, 1'b0);
      if (busB.busy) busyCycles++;
      if (busB.done) gotDone = 1;
    end
    vecApplied++;
    if (!gotDone) begin
      miscompares++;
      $display("[TB] FAIL lat2_timeout: done got 0 after 400 cycles, want 1");
    end
    vecApplied++;
    if (busyCycles != 258) begin
      miscompares++;
      $display("[TB] FAIL lat2_busy_len: got %0d cycles, want 258", busyCycles);
    end
    vecApplied++;
    if (busB.pass !== 1'b1 || busB.err_count !== 16'd0 || busB.vec_count !== 16'd256) begin
      miscompares++;
      $display("[TB] FAIL lat2_result: pass/err/vec got %0b/%0d/%0d, want 1/0/256",
               busB.pass, busB.err_count, busB.vec_count);
    end
  endtask

  task automatic test_reset_mid();
    kind = 0;
    repeat (3) applyStimulus('0, 1'b0, 1'b0, 1'b0);
    resetModel();
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) applyStimulus(W'(i), 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    vecApplied++;
    if (busA.vec_count !== 16'd100 || busA.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_progress: vec/busy got %0d/%0b, want 100/1", busA.vec_count, busA.busy);
    end
    #1 rst_n = 1'b0;
    #1;
    vecApplied++;
    if ({busA.busy, busA.done, busA.pass, busA.err_count, busA.vec_count,
         busA.first_fail_vec, busA.first_fail_valid} !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_async_reset: got busy=%0b vec=%0d err=%0d, want all 0",
               busA.busy, busA.vec_count, busA.err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    runCampaignA(0, -1);
    vecApplied++;
    if (busA.pass !== 1'b1 || busA.vec_count !== 16'd256 || busA.done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL after_reset_campaign: pass/vec/done got %0b/%0d/%0b, want 1/256/1",
               busA.pass, busA.vec_count, busA.done);
    end
  endtask

  task automatic test_start_ignored();
    runCampaignA(0, 50);
    vecApplied++;
    if (busA.vec_count !== 16'd256 || busA.pass !== 1'b1 || busA.done !== 1'b1 || busA.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_in_run: vec/pass/done/busy got %0d/%0b/%0b/%0b, want 256/1/1/0",
               busA.vec_count, busA.pass, busA.done, busA.busy);
    end
  endtask

  task automatic test_back_to_back();
    runCampaignA(1, -1);
    vecApplied++;
    if (busA.err_count !== 16'd1 || busA.done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: err/done got %0d/%0b, want 1/1", busA.err_count, busA.done);
    end
    resetModel();
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    vecApplied++;
    if (busA.done !== 1'b0 || busA.busy !== 1'b1 || busA.err_count !== 16'd0 || busA.vec_count !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL b2b_restart: done/busy/err/vec got %0b/%0b/%0d/%0d, want 0/1/0/0",
               busA.done, busA.busy, busA.err_count, busA.vec_count);
    end
    for (int i = 1; i < NV; i++) applyStimulus(W'(i), 1'b0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    vecApplied++;
    if (busA.err_count !== 16'd1 || busA.first_fail_vec !== 8'hFF || busA.pass !== 1'b0 ||
        busA.vec_count !== 16'd256 || busA.done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: err/ffvec/pass/vec/done got %0d/%02h/%0b/%0d/%0b, want 1/ff/0/256/1",
               busA.err_count, busA.first_fail_vec, busA.pass, busA.vec_count, busA.done);
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_ideal();
    test_stuck0();
    test_stuck1();
    test_two_stage_no_latency();
    test_latency2();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    repeat (3) @(negedge clk);
    vecApplied++;
    if (sbQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sbQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecApplied, miscompares);
    $finish;
  end

  // Backstop so a stuck run still ends with a report.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
